// File: rtl/muldiv_seq_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
package muldiv_seq_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned MD_CNT_W   = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic [DATA_WIDTH-1:0] md_abs(input logic [DATA_WIDTH-1:0] v,
                                                   input logic                  neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// EX-stage <-> multiply/divide sequencer handshake and operand bundle.
interface muldiv_seq_if;
  import muldiv_seq_pkg::*;

  logic                  start_i;
  md_op_e                op_i;
  logic [DATA_WIDTH-1:0] operand1_i;
  logic [DATA_WIDTH-1:0] operand2_i;
  logic                  flush_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  stall_o;

  modport master (
    output start_i, op_i, operand1_i, operand2_i, flush_i,
    input  busy_o, done_o, result_o, stall_o
  );

  modport slave (
    input  start_i, op_i, operand1_i, operand2_i, flush_i,
    output busy_o, done_o, result_o, stall_o
  );

endinterface

// File: rtl/muldiv_seq_md_sign_fix.sv
// Conditional two's-complement of product/quotient/remainder and result-word select.
module muldiv_seq_md_sign_fix
  import muldiv_seq_pkg::*;
(
  input  md_op_e                op_i,
  input  logic                  neg1_i,
  input  logic                  neg2_i,
  input  logic [DATA_WIDTH-1:0] hi_i,
  input  logic [DATA_WIDTH-1:0] lo_i,
  output logic [DATA_WIDTH-1:0] result_c_o
);

  localparam int unsigned W = DATA_WIDTH;

  logic [2*W-1:0] prod;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;

  // hi/lo hold {product} for multiplies and {remainder, quotient} for divides
  always_comb begin
    prod       = {hi_i, lo_i};
    quot       = lo_i;
    rem        = hi_i;
    result_c_o = '0;
    if (neg1_i ^ neg2_i) begin
      prod = -prod;
      quot = -quot;
    end
    if (neg1_i) rem = -rem;
    case (op_i)
      MD_MUL:                        result_c_o = prod[W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  result_c_o = prod[2*W-1:W];
      MD_DIV, MD_DIVU:               result_c_o = quot;
      default:                       result_c_o = rem;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M shift-add multiply / restoring divide sequencer beside the EX ALU.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplier for MUL* ops.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  muldiv_seq_if.slave   md_io
);

  localparam int unsigned W = DATA_WIDTH;
  localparam logic [1:0] S_IDLE = MD_IDLE;
  localparam logic [1:0] S_CALC = MD_CALC;
  localparam logic [1:0] S_DONE = MD_DONE;

  logic [1:0]          state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  md_op_e              op_q, op_d;
  logic                neg1_q, neg1_d, neg2_q, neg2_d;
  logic [W-1:0]        hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [W-1:0]        result_q, result_d;
  logic                done_q, done_d, busy_q, busy_d;

  md_op_e       op_in;
  logic [W-1:0] op_a, op_b, mag1, mag2, fix_res, div_diff;
  logic         sgn1, sgn2, is_div, div_zero, div_ovf, accept, div_ge;
  logic [W:0]   mul_sum, div_shift;

  muldiv_seq_md_sign_fix u_sign_fix (
    .op_i       (op_q),
    .neg1_i     (neg1_q),
    .neg2_i     (neg2_q),
    .hi_i       (hi_q),
    .lo_i       (lo_q),
    .result_c_o (fix_res)
  );

  // Operand decode and one iteration of each datapath
  always_comb begin
    op_in     = md_io.op_i;
    op_a      = md_io.operand1_i;
    op_b      = md_io.operand2_i;
    is_div    = op_in[2];
    sgn1      = ((op_in == MD_MULH) || (op_in == MD_MULHSU) ||
                 (op_in == MD_DIV)  || (op_in == MD_REM)) && op_a[W-1];
    sgn2      = ((op_in == MD_MULH) || (op_in == MD_DIV) || (op_in == MD_REM)) && op_b[W-1];
    mag1      = md_abs(op_a, sgn1);
    mag2      = md_abs(op_b, sgn2);
    div_zero  = is_div && (op_b == '0);
    div_ovf   = is_div && !op_in[0] && (op_a == {1'b1, {(W-1){1'b0}}}) && (&op_b);
    // done_q high means EX still presents the just-finished instruction
    accept    = md_io.start_i && !md_io.flush_i && !done_q;
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : {W{1'b0}})};
    div_shift = {hi_q, lo_q[W-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_diff  = W'(div_shift - {1'b0, opb_q});
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op_in;
          neg1_d  = sgn1;
          neg2_d  = sgn2;
          cnt_d   = MD_CNT_W'(W - 1);
          state_d = S_CALC;
          hi_d    = '0;
          if (is_div) begin
            lo_d  = mag1;
            opb_d = mag2;
            if (div_zero) begin
              state_d = S_DONE;
              neg1_d  = 1'b0;
              neg2_d  = 1'b0;
              hi_d    = op_a;
              lo_d    = '1;
            end else if (div_ovf) begin
              state_d = S_DONE;
              neg1_d  = 1'b0;
              neg2_d  = 1'b0;
              lo_d    = {1'b1, {(W-1){1'b0}}};
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            {hi_d, lo_d} = (2*W)'(mag1) * (2*W)'(mag2);
            opb_d        = mag1;
            state_d      = S_DONE;
`else
            lo_d  = mag2;
            opb_d = mag1;
`endif
          end
        end
      end

      S_CALC: begin
        if (md_io.flush_i) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[2]) begin
            hi_d = div_ge ? div_diff : div_shift[W-1:0];
            lo_d = {lo_q[W-2:0], div_ge};
          end else begin
            hi_d = mul_sum[W:1];
            lo_d = {mul_sum[0], lo_q[W-1:1]};
          end
          cnt_d = cnt_q - MD_CNT_W'(1);
          if (cnt_q == '0) state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (!md_io.flush_i) begin
          done_d   = 1'b1;
          result_d = fix_res;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= MD_MUL;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign md_io.busy_o   = busy_q;
  assign md_io.done_o   = done_q;
  assign md_io.result_o = result_q;
  assign md_io.stall_o  = md_io.start_i && !done_q && !md_io.flush_i;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: vector table plus flush/reset/back-to-back sequences.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  muldiv_seq_if md_if ();

  muldiv_seq dut (
    .clk   (clk),
    .rst   (rst),
    .md_io (md_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Holds start until done_o; lat counts edges from the accepting edge to done_o
  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stall_bad);
    md_if.start_i    = 1'b1;
    md_if.op_i       = op;
    md_if.operand1_i = a;
    md_if.operand2_i = b;
    res       = 32'hDEAD_BEEF;
    lat       = -1;
    stall_bad = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (md_if.done_o === 1'b1) begin
        res = md_if.result_o;
        lat = c - 1;
        break;
      end else if (md_if.stall_o !== 1'b1) begin
        stall_bad++;
      end
    end
    @(posedge clk); #1;
    md_if.start_i = 1'b0;
  endtask

  vec_t        vecs[20];
  logic [31:0] res;
  logic [31:0] vals[2];
  int          lat, sb, n, done_seen;
  logic        sw_pending;

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
    vecs[1]  = '{MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
    vecs[2]  = '{MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT};
    vecs[3]  = '{MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT};
    vecs[4]  = '{MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{MD_DIVU,   32'd100,      32'd7,        32'd14,       33};
    vecs[7]  = '{MD_REMU,   32'd100,      32'd7,        32'd2,        33};
    vecs[8]  = '{MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{MD_REM,    32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[12] = '{MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT};
    vecs[13] = '{MD_MUL,    32'h12345678, 32'h10,       32'h23456780, MUL_LAT};
    vecs[14] = '{MD_MULHU,  32'h80000000, 32'd4,        32'd2,        MUL_LAT};
    vecs[15] = '{MD_DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33};
    vecs[16] = '{MD_REM,    32'd20,       32'hFFFFFFFD, 32'd2,        33};
    vecs[17] = '{MD_REMU,   32'hFFFFFFFF, 32'h10,       32'hF,        33};
    vecs[18] = '{MD_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        33};
    vecs[19] = '{MD_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1};

    rst              = 1'b1;
    md_if.start_i    = 1'b0;
    md_if.flush_i    = 1'b0;
    md_if.op_i       = MD_MUL;
    md_if.operand1_i = '0;
    md_if.operand2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   32'(md_if.busy_o),  32'd0);
    chk("reset_done",   32'(md_if.done_o),  32'd0);
    chk("reset_result", md_if.result_o,     32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, sb);
      chk($sformatf("v%0d_result", i), res, vecs[i].exp);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_stall", i), 32'(sb), 32'd0);
      chk($sformatf("v%0d_done_pulse", i), 32'(md_if.done_o), 32'd0);
    end

    // Flush during CALC: no done, result kept, next op runs normally
    md_if.start_i    = 1'b1;
    md_if.op_i       = MD_MUL;
    md_if.operand1_i = 32'h1234;
    md_if.operand2_i = 32'h5678;
    done_seen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (md_if.done_o === 1'b1) done_seen++;
    end
    chk("flush_busy_calc", 32'(md_if.busy_o), 32'd1);
    md_if.flush_i = 1'b1;
    #1;
    chk("flush_stall", 32'(md_if.stall_o), 32'd0);
    @(posedge clk); #1;
    chk("flush_busy_after", 32'(md_if.busy_o), 32'd0);
    chk("flush_no_done", 32'(done_seen) + 32'(md_if.done_o), 32'd0);
    chk("flush_result_kept", md_if.result_o, vecs[19].exp);
    md_if.flush_i = 1'b0;
    run_op(MD_MUL, 32'd3, 32'd4, res, lat, sb);
    chk("post_flush_result", res, 32'd12);
    chk("post_flush_latency", 32'(lat), 32'(MUL_LAT));

    // Asynchronous reset mid-CALC
    md_if.start_i    = 1'b1;
    md_if.op_i       = MD_DIVU;
    md_if.operand1_i = 32'd1000;
    md_if.operand2_i = 32'd3;
    repeat (15) @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(md_if.busy_o), 32'd1);
    rst           = 1'b1;
    md_if.start_i = 1'b0;
    #1;
    chk("rst_busy",   32'(md_if.busy_o),  32'd0);
    chk("rst_done",   32'(md_if.done_o),  32'd0);
    chk("rst_result", md_if.result_o,     32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_idle", 32'(md_if.busy_o), 32'd0);

    // Back-to-back: DIV 20/3 then MUL 5x6 with start held throughout
    md_if.start_i    = 1'b1;
    md_if.op_i       = MD_DIV;
    md_if.operand1_i = 32'd20;
    md_if.operand2_i = 32'd3;
    n          = 0;
    sw_pending = 1'b0;
    vals[0]    = '0;
    vals[1]    = '0;
    for (int c = 0; c < 150 && n < 2; c++) begin
      @(posedge clk); #1;
      if (sw_pending) begin
        md_if.op_i       = MD_MUL;
        md_if.operand1_i = 32'd5;
        md_if.operand2_i = 32'd6;
        sw_pending       = 1'b0;
      end
      if (md_if.done_o === 1'b1) begin
        vals[n] = md_if.result_o;
        n++;
        if (n == 1) sw_pending = 1'b1;
      end
    end
    @(posedge clk); #1;
    md_if.start_i = 1'b0;
    chk("b2b_pulses", 32'(n), 32'd2);
    chk("b2b_first",  vals[0], 32'd6);
    chk("b2b_second", vals[1], 32'd30);
    chk("b2b_done_pulse", 32'(md_if.done_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer that sits beside the EX-stage ALU and is shared by all M-extension instructions.
- Accepts forwarded operands from EX, runs a multi-cycle shift-add multiply or restoring divide, and holds the pipeline through stall_o until the result is ready.
- The EX stage muxes result_o into alu_result when done_o is high.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start_i  input  1  EX holds an M-ext instruction; held high until done_o
op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand1_i  input  DATA_WIDTH  rs1 value, after forwarding
operand2_i  input  DATA_WIDTH  rs2 value, after forwarding
flush_i  input  1  EX instruction squashed; abort the operation
busy_o  output  1  state is not IDLE
done_o  output  1  result_o valid; one-cycle pulse
result_o  output  DATA_WIDTH  final result
stall_o  output  1  combinational: start_i & ~done_o & ~flush_i

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. Reset (asserted or mid-operation) forces IDLE and clears counter and all datapath registers. busy_o, done_o and result_o all reset to 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 and flush_i=0 -> latch op, operand signs and magnitudes.
  - Signed ops (MULH: both operands; MULHSU: rs1 only; DIV/REM: both) use absolute values.
  - Set counter = DATA_WIDTH-1; go to CALC.
- Fast path, evaluated in IDLE (next state DONE):
  - Divide by zero: quotient = all ones, remainder = operand1.
  - Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- CALC, one iteration per cycle:
  - Multiply: 2*DATA_WIDTH-bit shift-add on {acc, multiplier}.
  - Divide: restoring; shift remainder left, subtract divisor, set quotient bit if non-negative.
  - Counter decrements. At counter==0 go to DONE.
- DONE:
  - Apply sign correction. Product is negated if exactly one operand was negative (signed ops only). Quotient is negated if signs differ. Remainder takes the dividend's sign.
  - Select result: MUL = low word; MULH/MULHSU/MULHU = high word; DIV/DIVU = quotient; REM/REMU = remainder.
  - done_o=1 for this cycle only; return to IDLE unconditionally.
- Latency:
  - Normal ops: done_o asserts DATA_WIDTH+1 cycles after the accepting edge (33 for DATA_WIDTH=32).
  - Fast path: done_o asserts 1 cycle after the accepting edge.
- Result register: result_o holds its last value until the next DONE.
- Back-to-back ops: after DONE, IDLE may accept a new start_i on the very next cycle.
- A start_i seen during CALC/DONE is ignored; operands are sampled only in IDLE.
- flush_i:
  - In CALC or DONE: next state IDLE, done_o forced 0, result_o unchanged.
  - In IDLE: blocks acceptance.
  - Flush and DONE in the same cycle: flush wins, done_o=0.
- Unsigned handling: no sign correction is applied. MULHU/DIVU/REMU treat operands as unsigned throughout.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU compute through a single-cycle 2*DATA_WIDTH-bit multiplier in IDLE and go straight to DONE (latency 1). Divide ops are unchanged.
- Undefined: all multiplies use the iterative path with DATA_WIDTH+1 latency; no hardware multiplier is inferred.

Decomposition:
- core_pkg gains:
  - md_op_e: 3-bit enum mirroring funct3.
  - md_state_e: IDLE/CALC/DONE.
  - Constant MD_CNT_W = $clog2(DATA_WIDTH).
- One natural sub-module, md_sign_fix: combinational conditional two's-complement of the product, quotient and remainder plus result-word select. Used in DONE; keeps the FSM module focused on sequencing.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; done_o 33 cycles after accept; stall_o high every cycle until done.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU -> 2.
- Fast path:
  - DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with done_o 1 cycle after accept.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Flush and reset:
  - flush_i in CALC at cycle 10 -> no done_o, busy_o low next cycle; a new MUL 3x4 started next cycle -> 12.
  - rst asserted mid-CALC -> all outputs 0 immediately.
- Back-to-back: DIV 20/3 followed by MUL 5x6 with start_i held continuously -> two done_o pulses carrying 6 then 30, one IDLE cycle between them.
